// File: rtl/wallclock_pkg.sv
// Shared constants and types for the wall-clock button front end.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (hold-to-repeat pulses).
package wallclock_pkg;

    // System clock and default timing, all expressed in clock cycles.
    localparam int unsigned CLK_HZ               = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES      = CLK_HZ / 100;  // 10 ms
    localparam int unsigned REPEAT_DELAY_CYCLES  = CLK_HZ / 2;    // 500 ms
    localparam int unsigned REPEAT_PERIOD_CYCLES = CLK_HZ / 10;   // 100 ms

    // Per-channel hold-to-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Counter width able to hold max_count with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, press edge
// detect and, with BUTTON_AUTO_REPEAT_EN defined, the hold-to-repeat FSM.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES      = wallclock_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = wallclock_pkg::REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = wallclock_pkg::REPEAT_PERIOD_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);
    import wallclock_pkg::*;

    // Reject parameter values that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY_CYCLES < 1) begin : g_bad_delay
        $error("REPEAT_DELAY_CYCLES must be at least 1");
    end
    if (REPEAT_PERIOD_CYCLES < 1) begin : g_bad_period
        $error("REPEAT_PERIOD_CYCLES must be at least 1");
    end

    localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            btn_sync;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic            press_acc;

    // Two-flop synchronizer for the raw asynchronous input.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign btn_sync = sync_q[1];

    // Count consecutive samples that disagree with the stable level; the
    // counter never passes DB_LAST, so it cannot wrap.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (btn_sync != level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                level_d = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press_acc = level_d & ~level_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES)
                                      ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned      RPT_W    = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rel_acc;
    logic             dly_done, per_done;
    logic             rpt_fire;

    assign rel_acc  = level_q & ~level_d;
    assign dly_done = (rpt_cnt_q >= DLY_LAST);
    assign per_done = (rpt_cnt_q >= PER_LAST);

    // Repeat FSM state and hold-time counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Next state: an accepted release always wins over a timer expiry.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (press_acc) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (rel_acc) begin
                    state_d = IDLE;
                end else if (dly_done) begin
                    state_d = REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (rel_acc) begin
                    state_d = IDLE;
                end else if (!per_done) begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output: a repeat strobe on each expiry that is not cancelled by release.
    always_comb begin
        rpt_fire = 1'b0;
        case (state_q)
            DELAY:   rpt_fire = dly_done & ~rel_acc;
            REPEAT:  rpt_fire = per_done & ~rel_acc;
            default: rpt_fire = 1'b0;
        endcase
    end

    assign pulse_d = press_acc | rpt_fire;
`else
    assign pulse_d = press_acc;
`endif

    // Registered level, strobe and debounce counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the wall clock: N_BUTTONS independent channels of
// synchronize + debounce + press strobe. Optional hold-to-repeat is enabled
// by defining BUTTON_AUTO_REPEAT_EN.
module button_conditioner #(
    parameter int unsigned N_BUTTONS            = 3,
    parameter int unsigned DEBOUNCE_CYCLES      = wallclock_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = wallclock_pkg::REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = wallclock_pkg::REPEAT_PERIOD_CYCLES
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_chan (
            .clk_i   (CLK100MHZ),
            .rst_ni  (CPU_RESETN),
            .btn_i   (button[i]),
            .level_o (btn_level[i]),
            .pulse_o (btn_pulse[i])
        );
    end

endmodule
